// File: rtl/mod_counter_bcd.sv
// Modulo-MODULUS up/down counter with clock enable, synchronous restart,
// a combinational terminal count for cascading, a registered wrap pulse,
// and a registered BCD copy of the count.
//
// The BCD image is a counter in its own right. It steps in lock step with q
// using per-digit carry and borrow, so no binary-to-BCD converter sits in the
// display path.
module mod_counter_bcd #(
  parameter int unsigned MODULUS   = 25,
  parameter int unsigned WIDTH     = 5,
  parameter int unsigned DIGITS    = 2,
  parameter int unsigned RESET_VAL = 24
) (
  input  logic                  ck,
  input  logic                  rs,
  input  logic                  en,
  input  logic                  up,
  input  logic                  restart,
  output logic [WIDTH-1:0]      q,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  tc,
  output logic                  wrap
);

  // Elaboration-time BCD encoding of a constant.
  function automatic logic [4*DIGITS-1:0] to_bcd(input int unsigned v);
    logic [4*DIGITS-1:0] r;
    int unsigned         t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t           = t / 10;
    end
    return r;
  endfunction

  localparam logic [WIDTH-1:0]    Q_MAX    = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0]    Q_RST    = WIDTH'(RESET_VAL);
  localparam logic [4*DIGITS-1:0] BCD_MAX  = to_bcd(MODULUS - 1);
  localparam logic [4*DIGITS-1:0] BCD_RST  = to_bcd(RESET_VAL);
  localparam logic [4*DIGITS-1:0] BCD_ZERO = '0;

  logic                  at_max;
  logic                  at_zero;
  logic                  in_range;
  logic [4*DIGITS-1:0]   bcd_inc;
  logic [4*DIGITS-1:0]   bcd_dec;
  logic                  carry;
  logic                  borrow;

  // Boundary detection and the cascade terminal count. tc is not gated by restart.
  always_comb begin
    at_max   = (q == Q_MAX);
    at_zero  = (q == '0);
    in_range = (32'(q) < MODULUS);
    tc       = en & (up ? at_max : at_zero);
  end

  // Next BCD values for one step up and one step down, rippling digit by digit.
  always_comb begin
    bcd_inc = bcd;
    bcd_dec = bcd;
    carry   = 1'b1;
    borrow  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (bcd[4*i +: 4] == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
      if (borrow) begin
        if (bcd[4*i +: 4] == 4'd0) begin
          bcd_dec[4*i +: 4] = 4'd9;
        end else begin
          bcd_dec[4*i +: 4] = bcd[4*i +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
  end

  // Count register, BCD image and wrap pulse. Priority is rs > restart > en > hold.
  always_ff @(posedge ck) begin
    if (rs) begin
      q    <= Q_RST;
      bcd  <= BCD_RST;
      wrap <= 1'b0;
    end else if (restart) begin
      q    <= Q_RST;
      bcd  <= BCD_RST;
      wrap <= 1'b0;
    end else if (en) begin
      if (!in_range) begin
        // Recovery from an illegal count, which normal operation never produces.
        q    <= Q_RST;
        bcd  <= BCD_RST;
        wrap <= 1'b0;
      end else if (up) begin
        if (at_max) begin
          q    <= '0;
          bcd  <= BCD_ZERO;
          wrap <= 1'b1;
        end else begin
          q    <= q + WIDTH'(1);
          bcd  <= bcd_inc;
          wrap <= 1'b0;
        end
      end else begin
        if (at_zero) begin
          q    <= Q_MAX;
          bcd  <= BCD_MAX;
          wrap <= 1'b1;
        end else begin
          q    <= q - WIDTH'(1);
          bcd  <= bcd_dec;
          wrap <= 1'b0;
        end
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod_counter_bcd.sv
// Bench for mod_counter_bcd: the default mod-25 instance, plus a mod-60 and
// mod-40 pair chained through tc.
module tb_mod_counter_bcd;

  logic       ck = 1'b0;
  logic       rs, en, up, restart;
  logic [4:0] q;
  logic [7:0] bcd;
  logic       tc, wrap;

  logic       c_rs, c_en;
  logic [5:0] lo_q, hi_q;
  logic [7:0] lo_bcd, hi_bcd;
  logic       lo_tc, hi_tc, lo_wrap, hi_wrap;

  always #5 ck = ~ck;

  mod_counter_bcd dut (
    .ck(ck), .rs(rs), .en(en), .up(up), .restart(restart),
    .q(q), .bcd(bcd), .tc(tc), .wrap(wrap)
  );

  mod_counter_bcd #(.MODULUS(60), .WIDTH(6), .DIGITS(2), .RESET_VAL(0)) u_lo (
    .ck(ck), .rs(c_rs), .en(c_en), .up(1'b1), .restart(1'b0),
    .q(lo_q), .bcd(lo_bcd), .tc(lo_tc), .wrap(lo_wrap)
  );

  mod_counter_bcd #(.MODULUS(40), .WIDTH(6), .DIGITS(2), .RESET_VAL(0)) u_hi (
    .ck(ck), .rs(c_rs), .en(lo_tc), .up(1'b1), .restart(1'b0),
    .q(hi_q), .bcd(hi_bcd), .tc(hi_tc), .wrap(hi_wrap)
  );

  int          n_chk = 0;
  int          n_err = 0;
  int unsigned mq = 0;
  bit          mw = 1'b0;
  int          n_wraps;
  int          sat_r;
  int          sat_rst;
  int          sat_e;
  int          sat_u;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned dec2bcd(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 2; i++) begin
      r = r | ((v % 10) << (4 * i));
      v = v / 10;
    end
    return r;
  endfunction

  // Drive one cycle of inputs, check tc before the edge, then check the registered outputs.
  task automatic step(input bit r, input bit rst, input bit e, input bit u);
    rs = r; restart = rst; en = e; up = u;
    #1;
    chk("tc", 32'(tc), 32'(e && (u ? (mq == 24) : (mq == 0))));
    @(posedge ck);
    if (r || rst) begin
      mq = 24; mw = 1'b0;
    end else if (e) begin
      if (u) begin
        mw = (mq + 1 == 25);
        mq = (mq + 1) % 25;
      end else begin
        mw = (mq == 0);
        mq = (mq + 24) % 25;
      end
    end else begin
      mw = 1'b0;
    end
    #1;
    chk("q", 32'(q), mq);
    chk("bcd", 32'(bcd), dec2bcd(mq));
    chk("wrap", 32'(wrap), 32'(mw));
    if (wrap) n_wraps++;
  endtask

  initial begin
    rs = 1'b1; en = 1'b0; up = 1'b0; restart = 1'b0;
    c_rs = 1'b1; c_en = 1'b0;

    // Reset held for two edges.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_q", 32'(q), 24);
    chk("rst_bcd", 32'(bcd), 32'h24);
    chk("rst_wrap", 32'(wrap), 0);

    // Down count through zero, back to 24.
    n_wraps = 0;
    for (int i = 1; i <= 26; i++) begin
      step(0, 0, 1, 0);
      if (i == 14) chk("dn_q10", 32'(bcd), 32'h10);
      if (i == 15) chk("dn_borrow", 32'(bcd), 32'h09);
      if (i == 25) chk("dn_wrap", 32'(wrap), 1);
    end
    chk("dn_end_q", 32'(q), 23);
    chk("dn_wraps", 32'(n_wraps), 1);

    // rs asserted mid-count at q=7 (restart first so the path from 24 is known).
    step(0, 1, 0, 0);
    for (int i = 0; i < 17; i++) step(0, 0, 1, 0);
    chk("mid_q7", 32'(q), 7);
    step(1, 0, 1, 0);
    chk("mid_rs", 32'(q), 24);

    // Up count from 24: first edge wraps to 0, then 1..24.
    step(0, 1, 0, 0);
    for (int i = 1; i <= 25; i++) begin
      step(0, 0, 1, 1);
      if (i == 1)  chk("up_wrap", 32'(wrap), 1);
      if (i == 10) chk("up_09", 32'(bcd), 32'h09);
      if (i == 11) chk("up_carry", 32'(bcd), 32'h10);
    end
    chk("up_end", 32'(q), 24);

    // Enable low holds at 13.
    step(0, 1, 0, 0);
    for (int i = 0; i < 14; i++) step(0, 0, 1, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
    chk("hold_q", 32'(q), 13);

    // restart beats en at q=5.
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
    chk("pre_rst_q", 32'(q), 5);
    step(0, 1, 1, 1);
    chk("restart_q", 32'(q), 24);
    chk("restart_wrap", 32'(wrap), 0);

    // rs and restart together.
    step(1, 1, 1, 1);
    chk("rs_restart_q", 32'(q), 24);

    // Direction change at q=10.
    step(0, 1, 0, 0);
    for (int i = 0; i < 11; i++) step(0, 0, 1, 1);
    chk("dir_q10", 32'(q), 10);
    step(0, 0, 1, 1);
    chk("dir_q11", 32'(q), 11);
    step(0, 0, 1, 0);
    chk("dir_q10b", 32'(q), 10);
    step(0, 0, 1, 0);
    chk("dir_q9", 32'(q), 9);

    // Randomised traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      sat_r   = ($urandom_range(99) < 2)  ? 1 : 0;
      sat_rst = ($urandom_range(99) < 5)  ? 1 : 0;
      sat_e   = ($urandom_range(99) < 70) ? 1 : 0;
      sat_u   = int'($urandom_range(1));
      step(sat_r[0], sat_rst[0], sat_e[0], sat_u[0]);
    end

    // Cascade: mod-60 low stage feeds the mod-40 high stage.
    rs = 1'b0; restart = 1'b0; en = 1'b0;
    c_rs = 1'b1; c_en = 1'b1;
    @(posedge ck);
    #1;
    c_rs = 1'b0;
    chk("c_rst_lo", 32'(lo_q), 0);
    chk("c_rst_hi", 32'(hi_q), 0);
    n_wraps = 0;
    for (int k = 1; k <= 2400; k++) begin
      @(posedge ck);
      #1;
      chk("c_lo_q", 32'(lo_q), k % 60);
      chk("c_lo_bcd", 32'(lo_bcd), dec2bcd(k % 60));
      chk("c_hi_q", 32'(hi_q), (k / 60) % 40);
      chk("c_hi_bcd", 32'(hi_bcd), dec2bcd((k / 60) % 40));
      chk("c_lo_wrap", 32'(lo_wrap), 32'((k % 60) == 0));
      chk("c_hi_wrap", 32'(hi_wrap), 32'((k % 2400) == 0));
      if (hi_wrap) n_wraps++;
    end
    chk("c_hi_wraps", 32'(n_wraps), 1);
    chk("c_end_lo", 32'(lo_q), 0);
    chk("c_end_hi", 32'(hi_q), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
